// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// One access in flight; reads wait a fixed latency before data is returned.
module data_mem_arbiter #(
  parameter int unsigned AddrW      = 10,
  parameter int unsigned MemLatency = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req_i,
  input  logic             m0_we_i,
  input  logic [AddrW-1:0] m0_addr_i,
  input  logic [3:0]       m0_be_i,
  input  logic [31:0]      m0_wdata_i,
  output logic             m0_gnt_o,
  output logic             m0_done_o,
  output logic [31:0]      m0_rdata_o,
  input  logic             m1_req_i,
  input  logic             m1_we_i,
  input  logic [AddrW-1:0] m1_addr_i,
  input  logic [3:0]       m1_be_i,
  input  logic [31:0]      m1_wdata_i,
  output logic             m1_gnt_o,
  output logic             m1_done_o,
  output logic [31:0]      m1_rdata_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned CntW = (MemLatency > 1) ? $clog2(MemLatency) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic              last_gnt_q;
  logic              owner_q;
  logic              we_q;
  logic [AddrW-1:0]  addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [CntW-1:0]   cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              done0_q;
  logic              done1_q;
  logic [31:0]       rdata0_q;
  logic [31:0]       rdata1_q;

  logic sel1;
  logic grant;

  // m1 wins when it is the only requester, or on a tie when m0 was granted last.
  always_comb begin
    sel1     = m1_req_i & (~m0_req_i | ~last_gnt_q);
    grant    = (state_q == StIdle) & ~rst & (m0_req_i | m1_req_i);
    m0_gnt_o = grant & ~sel1;
    m1_gnt_o = grant & sel1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q    <= sel1;
            last_gnt_q <= sel1;
            we_q       <= sel1 ? m1_we_i    : m0_we_i;
            addr_q     <= sel1 ? m1_addr_i  : m0_addr_i;
            be_q       <= sel1 ? m1_be_i    : m0_be_i;
            wdata_q    <= sel1 ? m1_wdata_i : m0_wdata_i;
            mem_en_q   <= 1'b1;
            mem_we_q   <= sel1 ? m1_we_i : m0_we_i;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (we_q) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= StResp;
          end else begin
            cnt_q   <= CntW'(MemLatency - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (owner_q) rdata1_q <= mem_rdata_i;
            else         rdata0_q <= mem_rdata_i;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign m0_done_o   = done0_q;
  assign m1_done_o   = done1_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: latency-1 instance (a) and latency-3 instance (b).
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instance a, MEM_LATENCY = 1
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [9:0]  m0_addr = 0, m1_addr = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, mem_rdata = 0;
  logic        m0_gnt, m0_done, m1_gnt, m1_done, mem_en, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;

  // Instance b, MEM_LATENCY = 3
  logic        b_m0_req = 0;
  logic [9:0]  b_m0_addr = 0;
  logic [31:0] b_mem_rdata = 0;
  logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done, b_mem_en, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [9:0]  b_mem_addr;
  logic [3:0]  b_mem_be;

  data_mem_arbiter #(.AddrW(10), .MemLatency(1)) u_a (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_rdata_o(m1_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  data_mem_arbiter #(.AddrW(10), .MemLatency(3)) u_b (
    .clk(clk), .rst(rst),
    .m0_req_i(b_m0_req), .m0_we_i(1'b0), .m0_addr_i(b_m0_addr), .m0_be_i(4'h0),
    .m0_wdata_i(32'h0), .m0_gnt_o(b_m0_gnt), .m0_done_o(b_m0_done), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(10'h0), .m1_be_i(4'h0),
    .m1_wdata_i(32'h0), .m1_gnt_o(b_m1_gnt), .m1_done_o(b_m1_done), .m1_rdata_o(b_m1_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_be_o(b_mem_be),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    bad++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    total++; if (m0_gnt !== 1'b0) fail("rst_gnt0", m0_gnt, 1'b0);
    total++; if (mem_en !== 1'b0) fail("rst_mem_en", mem_en, 1'b0);
    total++; if (m0_rdata !== 32'h0) fail("rst_rdata0", m0_rdata, 32'h0);
    nxt();
    rst = 1'b0;

    // m0 read 0x010, L=1: gnt c0, mem_en c1, done c3
    nxt();
    m0_req = 1; m0_we = 0; m0_addr = 10'h010; m0_be = 4'hF;
    #2;
    total++; if (m0_gnt !== 1'b1) fail("rd_gnt0_c0", m0_gnt, 1'b1);
    total++; if (m1_gnt !== 1'b0) fail("rd_gnt1_c0", m1_gnt, 1'b0);
    total++; if (mem_en !== 1'b0) fail("rd_mem_en_c0", mem_en, 1'b0);
    nxt();
    m0_req = 0; m0_addr = 10'h000;
    #2;
    total++; if (mem_en !== 1'b1) fail("rd_mem_en_c1", mem_en, 1'b1);
    total++; if (mem_we !== 1'b0) fail("rd_mem_we_c1", mem_we, 1'b0);
    total++; if (mem_addr !== 10'h010) fail("rd_mem_addr_c1", mem_addr, 10'h010);
    total++; if (mem_be !== 4'hF) fail("rd_mem_be_c1", mem_be, 4'hF);
    total++; if (m0_gnt !== 1'b0) fail("rd_gnt0_c1", m0_gnt, 1'b0);
    nxt();
    mem_rdata = 32'hDEADBEEF;
    #2;
    total++; if (mem_en !== 1'b0) fail("rd_mem_en_c2", mem_en, 1'b0);
    total++; if (m0_done !== 1'b0) fail("rd_done_c2", m0_done, 1'b0);
    nxt();
    mem_rdata = 32'h0;
    #2;
    total++; if (m0_done !== 1'b1) fail("rd_done_c3", m0_done, 1'b1);
    total++; if (m0_rdata !== 32'hDEADBEEF) fail("rd_rdata_c3", m0_rdata, 32'hDEADBEEF);
    nxt();
    #2;
    total++; if (m0_done !== 1'b0) fail("rd_done_c4", m0_done, 1'b0);
    total++; if (m0_rdata !== 32'hDEADBEEF) fail("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // m1 write 0x3FC be=0011 wdata=0x1234: mem_en c1, done c2
    m1_req = 1; m1_we = 1; m1_addr = 10'h3FC; m1_be = 4'b0011; m1_wdata = 32'h1234;
    #1;
    total++; if (m1_gnt !== 1'b1) fail("wr_gnt1_c0", m1_gnt, 1'b1);
    nxt();
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
    #2;
    total++; if (mem_en !== 1'b1) fail("wr_mem_en_c1", mem_en, 1'b1);
    total++; if (mem_we !== 1'b1) fail("wr_mem_we_c1", mem_we, 1'b1);
    total++; if (mem_addr !== 10'h3FC) fail("wr_mem_addr_c1", mem_addr, 10'h3FC);
    total++; if (mem_be !== 4'b0011) fail("wr_mem_be_c1", mem_be, 4'b0011);
    total++; if (mem_wdata !== 32'h1234) fail("wr_mem_wdata_c1", mem_wdata, 32'h1234);
    nxt();
    #2;
    total++; if (m1_done !== 1'b1) fail("wr_done1_c2", m1_done, 1'b1);
    total++; if (m0_done !== 1'b0) fail("wr_done0_c2", m0_done, 1'b0);
    total++; if (mem_we !== 1'b0) fail("wr_mem_we_c2", mem_we, 1'b0);
    total++; if (mem_addr !== 10'h3FC) fail("wr_addr_hold", mem_addr, 10'h3FC);
    total++; if (m1_rdata !== 32'h0) fail("wr_rdata1_zero", m1_rdata, 32'h0);

    // Reset, then both ports request reads continuously
    rst = 1;
    #1;
    total++; if (mem_addr !== 10'h0) fail("rst2_addr", mem_addr, 10'h0);
    total++; if (m0_rdata !== 32'h0) fail("rst2_rdata0", m0_rdata, 32'h0);
    nxt();
    rst = 0;
    nxt();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
    m0_addr = 10'h100; m1_addr = 10'h200;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) nxt();
      mem_rdata = 32'hA000_0000 + 32'(k);
      #2;
      total++;
      if (m0_gnt !== ((k % 8) == 0))
        fail($sformatf("ct_gnt0_k%0d", k), m0_gnt, ((k % 8) == 0));
      total++;
      if (m1_gnt !== ((k % 8) == 4))
        fail($sformatf("ct_gnt1_k%0d", k), m1_gnt, ((k % 8) == 4));
      if (k == 3) begin
        total++; if (m0_done !== 1'b1) fail("ct_done0_k3", m0_done, 1'b1);
        total++; if (m0_rdata !== 32'hA000_0002) fail("ct_rdata0_k3", m0_rdata, 32'hA000_0002);
      end
      if (k == 5) begin
        total++; if (mem_addr !== 10'h200) fail("ct_addr_k5", mem_addr, 10'h200);
      end
      if (k == 7) begin
        total++; if (m1_done !== 1'b1) fail("ct_done1_k7", m1_done, 1'b1);
        total++; if (m1_rdata !== 32'hA000_0006) fail("ct_rdata1_k7", m1_rdata, 32'hA000_0006);
        total++; if (m0_rdata !== 32'hA000_0002) fail("ct_rdata0_k7", m0_rdata, 32'hA000_0002);
      end
      if (k == 11) begin
        total++;
        if (m0_rdata !== 32'hA000_000A) fail("ct_rdata0_k11", m0_rdata, 32'hA000_000A);
      end
    end
    nxt();
    m0_req = 0; m1_req = 0;
    #2;
    total++; if (m0_gnt !== 1'b0) fail("ct_idle_gnt0", m0_gnt, 1'b0);
    total++; if (m1_gnt !== 1'b0) fail("ct_idle_gnt1", m1_gnt, 1'b0);

    // m1 read, then reset while in WAIT with both ports requesting
    m1_req = 1;
    #1;
    total++; if (m1_gnt !== 1'b1) fail("rw_gnt1", m1_gnt, 1'b1);
    nxt();
    m1_req = 0;
    nxt();
    m0_req = 1; m1_req = 1;
    rst = 1;
    #1;
    total++; if (mem_en !== 1'b0) fail("rw_mem_en", mem_en, 1'b0);
    total++; if (m1_done !== 1'b0) fail("rw_done1", m1_done, 1'b0);
    total++; if (m0_gnt !== 1'b0) fail("rw_gnt0", m0_gnt, 1'b0);
    total++; if (m1_gnt !== 1'b0) fail("rw_gnt1_rst", m1_gnt, 1'b0);
    total++; if (m1_rdata !== 32'h0) fail("rw_rdata1_clr", m1_rdata, 32'h0);
    nxt();
    nxt();
    rst = 0;
    #1;
    total++; if (m0_gnt !== 1'b1) fail("rw_after_gnt0", m0_gnt, 1'b1);
    total++; if (m1_gnt !== 1'b0) fail("rw_after_gnt1", m1_gnt, 1'b0);
    nxt();
    m0_req = 0; m1_req = 0;
    for (int k = 0; k < 4; k++) nxt();

    // Instance b, L=3: done exactly at c5, data sampled at c4 only
    b_m0_req = 1; b_m0_addr = 10'h044;
    #1;
    total++; if (b_m0_gnt !== 1'b1) fail("l3_gnt_c0", b_m0_gnt, 1'b1);
    nxt();
    b_m0_req = 0;
    #1;
    total++; if (b_mem_en !== 1'b1) fail("l3_mem_en_c1", b_mem_en, 1'b1);
    for (int c = 2; c <= 5; c++) begin
      nxt();
      case (c)
        2: b_mem_rdata = 32'h1111_1111;
        3: b_mem_rdata = 32'h2222_2222;
        4: b_mem_rdata = 32'hCAFE_F00D;
        default: b_mem_rdata = 32'h3333_3333;
      endcase
      #1;
      total++;
      if (b_m0_done !== (c == 5)) fail($sformatf("l3_done_c%0d", c), b_m0_done, (c == 5));
      total++;
      if (b_mem_en !== 1'b0) fail($sformatf("l3_mem_en_c%0d", c), b_mem_en, 1'b0);
    end
    total++; if (b_m0_rdata !== 32'hCAFE_F00D) fail("l3_rdata_c5", b_m0_rdata, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
